// File: rtl/mdio_master_pkg.sv
// rtl/mdio_master_pkg.sv - shared states, frame constants and frame builder for the MDIO master
package mdio_master_pkg;

  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, DONE} state_e;

  localparam logic [1:0] ST_BITS  = 2'b01;
  localparam logic [1:0] OP_RD    = 2'b10;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] TA_WR    = 2'b10;
  localparam int         CMD_LEN  = 14;
  localparam int         DATA_LEN = 16;

  // Reads carry all-ones in the data field; the PHY owns the line then anyway.
  function automatic logic [31:0] build_frame(input logic we, input logic [4:0] phy,
                                              input logic [4:0] regad, input logic [15:0] wdata);
    return {ST_BITS, (we ? OP_WR : OP_RD), phy, regad, TA_WR, (we ? wdata : 16'hFFFF)};
  endfunction

endpackage

// File: rtl/mdio_master_ctrl_if.sv
// rtl/mdio_master_ctrl_if.sv - request/response channel between register file and MDIO master
interface mdio_master_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_phy_addr_i;
  logic [4:0]  req_reg_addr_i;
  logic [15:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  modport master (
    output req_valid_i, req_we_i, req_phy_addr_i, req_reg_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_phy_addr_i, req_reg_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/mdio_clk_gen.sv
// rtl/mdio_clk_gen.sv - MDC divider with rise/fall strobes; held at phase 0, MDC low while disabled
module mdio_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);
  logic [7:0] phase_q, phase_d;
  logic       mdc_q, mdc_d;
  logic       tc;

  always_comb begin
    tc      = (phase_q == 8'(CLK_DIV - 1));
    phase_d = 8'd0;
    mdc_d   = 1'b0;
    if (en_i) begin
      phase_d = tc ? 8'd0 : phase_q + 8'd1;
      mdc_d   = tc ? ~mdc_q : mdc_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= 8'd0;
      mdc_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      mdc_q   <= mdc_d;
    end
  end

  // Strobes mark the cycle whose closing edge moves MDC, so they never coincide.
  assign rise_o = en_i & tc & ~mdc_q;
  assign fall_o = en_i & tc & mdc_q;
  assign mdc_o  = mdc_q;
endmodule

// File: rtl/mdio_master_ctrl.sv
// rtl/mdio_master_ctrl.sv - Clause-22 MDIO master; MDIO_PREAMBLE_SUPPRESS_EN adds pre_skip_i
module mdio_master_ctrl
  import mdio_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mdio_master_ctrl_if.slave req_if,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic              pre_skip_i,
`endif
  output logic              mdc_o,
  output logic              mdio_o,
  output logic              mdio_oe_o,
  input  logic              mdio_i
);
  state_e      state_q, state_d, next_state;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] sr_q, sr_d;
  logic [15:0] rd_sh_q, rd_sh_d, rsp_rdata_q, rsp_rdata_d;
  logic        we_q, we_d, err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic        in_frame, last_bit, skip_pre, rise, fall;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign skip_pre = pre_skip_i;
`else
  assign skip_pre = 1'b0;
`endif

  assign in_frame = state_q inside {PRE, CMD, TA, DATA};

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (in_frame),
    .mdc_o  (mdc_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    state_d     = state_q;
    next_state  = state_q;
    last_bit    = 1'b0;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    we_d        = we_q;
    err_d       = err_q;
    rd_sh_d     = rd_sh_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: if (req_if.req_valid_i) begin
        sr_d      = build_frame(req_if.req_we_i, req_if.req_phy_addr_i,
                                req_if.req_reg_addr_i, req_if.req_wdata_i);
        we_d      = req_if.req_we_i;
        bit_cnt_d = 6'd0;
        err_d     = 1'b0;
        rd_sh_d   = 16'hFFFF;
        state_d   = skip_pre ? CMD : PRE;
      end
      PRE: begin
        last_bit   = (bit_cnt_q == 6'(PRE_LEN - 1));
        next_state = CMD;
      end
      CMD: begin
        last_bit   = (bit_cnt_q == 6'(CMD_LEN - 1));
        next_state = TA;
      end
      TA: begin
        last_bit   = (bit_cnt_q == 6'd1);
        next_state = DATA;
      end
      DATA: begin
        last_bit   = (bit_cnt_q == 6'(DATA_LEN - 1));
        next_state = DONE;
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = ~we_q & err_q;
        if (!we_q) rsp_rdata_d = rd_sh_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Preamble bits are constant ones, so the shift register waits for CMD.
    if (fall) begin
      if (state_q != PRE) sr_d = {sr_q[30:0], 1'b1};
      if (last_bit) begin
        bit_cnt_d = 6'd0;
        state_d   = next_state;
      end else begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end
    end

    if (rise && !we_q) begin
      if (state_q == TA && bit_cnt_q == 6'd1) err_d = mdio_i;
      if (state_q == DATA) rd_sh_d = {rd_sh_q[14:0], mdio_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 6'd0;
      sr_q        <= 32'hFFFF_FFFF;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      rd_sh_q     <= 16'hFFFF;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      we_q        <= we_d;
      err_q       <= err_d;
      rd_sh_q     <= rd_sh_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mdio_o    = (state_q inside {CMD, TA, DATA}) ? sr_q[31] : 1'b1;
  assign mdio_oe_o = (state_q inside {PRE, CMD}) | ((state_q inside {TA, DATA}) & we_q);

  assign req_if.req_ready_o = (state_q == IDLE);
  assign req_if.busy_o      = (state_q != IDLE);
  assign req_if.rsp_valid_o = rsp_valid_q;
  assign req_if.rsp_rdata_o = rsp_rdata_q;
  assign req_if.rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_mdio_master_ctrl.sv
// tb/tb_mdio_master_ctrl.sv - scoreboard bench for mdio_master_ctrl; honours MDIO_PREAMBLE_SUPPRESS_EN
module tb_mdio_master_ctrl;
  localparam int CLK_DIV  = 4;
  localparam int PRE_LEN  = 32;
  localparam int LAT_FULL = (PRE_LEN + 32) * 2 * CLK_DIV + 1;
  localparam int LAT_SKIP = 32 * 2 * CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdc, mdio_o, mdio_oe;
  logic mdio_i = 1'b1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  logic pre_skip = 1'b0;
`endif

  mdio_master_ctrl_if bus();

  mdio_master_ctrl #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_if    (bus),
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    .pre_skip_i(pre_skip),
`endif
    .mdc_o     (mdc),
    .mdio_o    (mdio_o),
    .mdio_oe_o (mdio_oe),
    .mdio_i    (mdio_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] rdata;
    logic        err;
    logic [63:0] bits;
    logic [63:0] oe;
    int          nbits;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic        phy_on;
    logic [15:0] phy_data;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise_idx = 0;
  int          acc_cnt = 0;
  int          rsp_cnt = 0;
  int          acc_cyc = 0;
  logic [63:0] phy_bits = '1;
  logic [63:0] cap_bits = '0;
  logic [63:0] cap_oe = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] phy, input logic [4:0] regad,
                              input logic [15:0] wd, input logic [15:0] rd, input logic err,
                              input logic skip);
    exp_t        e;
    logic [31:0] f;
    logic [31:0] o;
    f = {2'b01, (we ? 2'b01 : 2'b10), phy, regad, 2'b10, (we ? wd : 16'hFFFF)};
    o = we ? 32'hFFFF_FFFF : {14'h3FFF, 18'h0};
    e.we    = we;
    e.rdata = rd;
    e.err   = err;
    e.bits  = skip ? {32'h0, f} : {32'hFFFF_FFFF, f};
    e.oe    = skip ? {32'h0, o} : {32'hFFFF_FFFF, o};
    e.nbits = skip ? 32 : 64;
    e.lat   = skip ? LAT_SKIP : LAT_FULL;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor and PHY model: capture on MDC rise, answer reads, score responses.
  initial begin
    logic mdc_prev;
    logic pulse_pend;
    exp_t e;
    mdc_prev   = 1'b0;
    pulse_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mdc_prev   = 1'b0;
        pulse_pend = 1'b0;
      end else begin
        if (pulse_pend) check("rsp_pulse_width", bus.rsp_valid_o, 1'b0);
        pulse_pend = 1'b0;
        if (mdc && !mdc_prev) begin
          cap_bits = {cap_bits[62:0], mdio_o};
          cap_oe   = {cap_oe[62:0], mdio_oe};
          rise_idx++;
          mdio_i   = (rise_idx < 64) ? phy_bits[63 - rise_idx] : 1'b1;
        end
        mdc_prev = mdc;
        if (bus.rsp_valid_o) begin
          rsp_cnt++;
          pulse_pend = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=rsp_valid required=none");
          end else begin
            e = sb.pop_front();
            check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
            check("rise_count", 64'(rise_idx), 64'(e.nbits));
            check("mdio_bits", cap_bits & e.oe, e.bits & e.oe);
            check("mdio_oe", cap_oe, e.oe);
            check("rsp_err", bus.rsp_err_o, e.err);
            if (!e.we) check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
            check("done_pins", {mdc, mdio_oe, mdio_o}, 3'b001);
            check("ready_at_rsp", bus.req_ready_o, 1'b1);
          end
        end
        if (bus.req_valid_i && bus.req_ready_o) begin
          acc_cnt++;
          acc_cyc  = cyc + 1;
          rise_idx = 0;
          cap_bits = '0;
          cap_oe   = '0;
          mdio_i   = phy_bits[63];
        end
      end
    end
  end

  task automatic drive_req(input logic we, input logic [4:0] phy, input logic [4:0] regad,
                           input logic [15:0] wd);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_phy_addr_i = phy;
    bus.req_reg_addr_i = regad;
    bus.req_wdata_i    = wd;
  endtask

  task automatic send(input logic we, input logic [4:0] phy, input logic [4:0] regad,
                      input logic [15:0] wd);
    int t;
    t = 0;
    @(posedge clk); #1;
    while (!bus.req_ready_o && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    drive_req(we, phy, regad, wd);
    @(posedge clk); #1;
    // Scramble fields after accept: only the accept cycle may matter.
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = ~we;
    bus.req_phy_addr_i = ~phy;
    bus.req_reg_addr_i = ~regad;
    bus.req_wdata_i    = ~wd;
  endtask

  task automatic wait_rsp(input int n);
    int t;
    t = 0;
    while (rsp_cnt < n && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (rsp_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout actual=%0d required=%0d", rsp_cnt, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   n;
    int   t;
    int   a_acc;
    vt[0] = '{1'b1, 5'd1,  5'd5,  16'hA5A5, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vt[1] = '{1'b0, 5'd0,  5'd3,  16'h0000, 1'b1, 16'h0003, 16'h0003, 1'b0};
    vt[2] = '{1'b0, 5'd0,  5'd3,  16'h0000, 1'b0, 16'h0000, 16'hFFFF, 1'b1};
    vt[3] = '{1'b1, 5'd31, 5'd31, 16'h5A0F, 1'b0, 16'h0000, 16'h0000, 1'b0};
    vt[4] = '{1'b0, 5'd5,  5'd10, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0};

    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_phy_addr_i = 5'd0;
    bus.req_reg_addr_i = 5'd0;
    bus.req_wdata_i    = 16'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mdc", mdc, 1'b0);
    check("rst_mdio", mdio_o, 1'b1);
    check("rst_oe", mdio_oe, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
    check("rst_rdata", bus.rsp_rdata_o, 16'h0);
    check("rst_err", bus.rsp_err_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", bus.req_ready_o, 1'b1);

    for (int i = 0; i < 5; i++) begin
      phy_bits = vt[i].phy_on ? {32'hFFFF_FFFF, 14'h3FFF, 2'b10, vt[i].phy_data} : '1;
      sb.push_back(mk(vt[i].we, vt[i].phy, vt[i].regad, vt[i].wdata,
                      vt[i].exp_rdata, vt[i].exp_err, 1'b0));
      n = rsp_cnt + 1;
      send(vt[i].we, vt[i].phy, vt[i].regad, vt[i].wdata);
      wait_rsp(n);
    end

    // Second request held valid through a whole frame.
    phy_bits = '1;
    sb.push_back(mk(1'b1, 5'd3, 5'd7, 16'h1111, 16'h0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 5'd4, 5'd8, 16'h2222, 16'h0, 1'b0, 1'b0));
    n = rsp_cnt;
    t = acc_cnt;
    @(posedge clk); #1;
    drive_req(1'b1, 5'd3, 5'd7, 16'h1111);
    @(posedge clk); #1;
    a_acc = acc_cyc;
    drive_req(1'b1, 5'd4, 5'd8, 16'h2222);
    repeat (100) @(posedge clk);
    #1;
    check("busy_mid_frame", bus.busy_o, 1'b1);
    check("ready_mid_frame", bus.req_ready_o, 1'b0);
    check("no_accept_while_busy", 64'(acc_cnt - t), 64'd1);
    begin
      int w;
      w = 0;
      while (acc_cnt < t + 2 && w < 2000) begin
        @(posedge clk); #1;
        w++;
      end
    end
    bus.req_valid_i = 1'b0;
    check("second_accept_gap", 64'(acc_cyc - a_acc), 64'(LAT_FULL + 1));
    wait_rsp(n + 2);

    // Reset in the middle of a write frame.
    sb.push_back(mk(1'b1, 5'd9, 5'd9, 16'hCAFE, 16'h0, 1'b0, 1'b0));
    send(1'b1, 5'd9, 5'd9, 16'hCAFE);
    t = 0;
    while (rise_idx < 20 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_bit20", 64'(rise_idx), 64'd20);
    #2;
    rst = 1'b1;
    #1;
    check("arst_mdc", mdc, 1'b0);
    check("arst_mdio", mdio_o, 1'b1);
    check("arst_oe", mdio_oe, 1'b0);
    check("arst_busy", bus.busy_o, 1'b0);
    check("arst_rsp_valid", bus.rsp_valid_o, 1'b0);
    sb.delete();
    n = rsp_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    check("no_rsp_after_abort", 64'(rsp_cnt), 64'(n));
    sb.push_back(mk(1'b1, 5'd9, 5'd9, 16'hCAFE, 16'h0, 1'b0, 1'b0));
    send(1'b1, 5'd9, 5'd9, 16'hCAFE);
    wait_rsp(n + 1);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    pre_skip = 1'b1;
    sb.push_back(mk(1'b1, 5'd2, 5'd0, 16'h1234, 16'h0, 1'b0, 1'b1));
    n = rsp_cnt + 1;
    send(1'b1, 5'd2, 5'd0, 16'h1234);
    pre_skip = 1'b0;
    wait_rsp(n);
`endif

    repeat (20) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
